// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and fills the IF/ID pipeline register, with boot bubble, stall, redirect/flush and halt.
//
// state | meaning
// BOOT  | one-cycle bubble after reset release; pc parked at RESET_PC
// RUN   | fetching one instruction per edge unless stalled or redirected
// HALT  | pc left the program image; only an in-range redirect restarts fetch
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 32
) (
    input  logic        clk,
    input  logic        clrn,
    output logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [31:0] ROM_WORDS_W = 32'(ROM_WORDS);

    logic [1:0]  state;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        pc_ok;
    logic        target_ok;

    // Offset is computed modulo 2^32, so addresses below RESET_PC wrap high and fail.
    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] word_off;
        word_off = (addr - RESET_PC) >> 2;
        return word_off < ROM_WORDS_W;
    endfunction

    assign target    = {redirect_pc[31:2], 2'b00};
    assign pc_plus4  = pc + 32'd4;
    assign pc_ok     = in_range(pc);
    assign target_ok = in_range(target);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_inst  <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'd0;
        end else begin
            case (state)
                BOOT: begin
                    state       <= RUN;
                    if_id_valid <= 1'b0;
                end
                RUN: begin
                    if (redirect) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                    end else if (stall) begin
                        pc          <= pc;
                    end else if (!pc_ok) begin
                        state       <= HALT;
                        halted      <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else begin
                        if_id_inst  <= inst;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'd1;
                        end
                    end
                end
                HALT: begin
                    if_id_valid <= 1'b0;
                    if (redirect && target_ok) begin
                        pc     <= target;
                        halted <= 1'b0;
                        state  <= RUN;
                    end
                end
                default: begin
                    state       <= BOOT;
                    pc          <= RESET_PC;
                    if_id_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: an 8-word ROM model drives inst, and each step is
// checked against hand-computed pipeline contents.
module tb_if_stage;

    logic        clk;
    logic        clrn;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rom [0:7];

    if_stage #(.RESET_PC(32'h0000_0000), .ROM_WORDS(8)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .pc          (pc),
        .inst        (inst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        inst = 32'hDEAD_BEEF;
        if (pc[31:5] == 27'd0) inst = rom[pc[4:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] exp_inst,
                               input logic [31:0] exp_pc4, input logic [15:0] exp_cnt);
        check({tag, "_inst"}, if_id_inst, exp_inst);
        check({tag, "_pc4"}, if_id_pc4, exp_pc4);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        check({tag, "_pc"}, pc, exp_pc4);
        check({tag, "_cnt"}, 32'(fetch_count), 32'(exp_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_inst"}, if_id_inst, 32'h0);
        check({tag, "_pc4"}, if_id_pc4, 32'h0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_cnt"}, 32'(fetch_count), 32'd0);
    endtask

    initial begin
        rom[0] = 32'h00000820; rom[1] = 32'h8C220000;
        rom[2] = 32'h8C230004; rom[3] = 32'h00431020;
        rom[4] = 32'h8C230008; rom[5] = 32'h10430001;
        rom[6] = 32'hAC20000C; rom[7] = 32'hAC22000C;

        clrn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #2;
        check_reset_vals("reset");
        tick();
        tick();
        clrn = 1'b1;

        // BOOT bubble
        tick();
        check("boot_valid", 32'(if_id_valid), 32'd0);
        check("boot_pc", pc, 32'h0);

        tick(); check_fetch("f0", 32'h00000820, 32'h4, 16'd1);
        tick(); check_fetch("f1", 32'h8C220000, 32'h8, 16'd2);

        // stall for three cycles at pc=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_fetch("stall", 32'h8C220000, 32'h8, 16'd2);
        end
        stall = 1'b0;

        for (int i = 2; i < 8; i++) begin
            tick();
            check_fetch("run", rom[i], 32'((i + 1) * 4), 16'(i + 1));
        end

        // end of image
        tick();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(if_id_valid), 32'd0);
        check("halt_pc", pc, 32'h20);
        check("halt_cnt", 32'(fetch_count), 32'd8);

        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        check("halt_oor_halted", 32'(halted), 32'd1);
        check("halt_oor_pc", pc, 32'h20);

        redirect_pc = 32'h0;
        tick();
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_pc", pc, 32'h0);
        check("restart_valid", 32'(if_id_valid), 32'd0);
        redirect = 1'b0;
        tick(); check_fetch("restart_f0", 32'h00000820, 32'h4, 16'd9);

        for (int i = 1; i < 5; i++) begin
            tick();
            check_fetch("run2", rom[i], 32'((i + 1) * 4), 16'(9 + i));
        end

        // redirect with unaligned target at pc=0x14
        redirect = 1'b1; redirect_pc = 32'h1D;
        tick();
        check("redir_pc", pc, 32'h1C);
        check("redir_valid", 32'(if_id_valid), 32'd0);
        check("redir_cnt", 32'(fetch_count), 32'd13);
        redirect = 1'b0;
        tick(); check_fetch("redir_tgt", 32'hAC22000C, 32'h20, 16'd14);

        // redirect beats stall
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h8;
        tick();
        check("rs_pc", pc, 32'h8);
        check("rs_valid", 32'(if_id_valid), 32'd0);
        check("rs_halted", 32'(halted), 32'd0);
        redirect = 1'b0; stall = 1'b0;
        tick(); check_fetch("rs_tgt", 32'h8C230004, 32'hC, 16'd15);
        tick(); check_fetch("pre_rst", 32'h00431020, 32'h10, 16'd16);

        // asynchronous reset mid-run at pc=0x10
        #2;
        clrn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick();
        clrn = 1'b1;
        tick();
        check("reboot_valid", 32'(if_id_valid), 32'd0);
        check("reboot_pc", pc, 32'h0);
        tick(); check_fetch("reboot_f0", 32'h00000820, 32'h4, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
